// File: rtl/mul_share_arbiter_pkg.sv
// Shared constants and tag record for the shared multiplier arbiter.
// Multiplier widths, pipeline depth and the {valid, id} tag type.
package mul_share_arbiter_pkg;

  localparam int MUL_IN_W   = 16;
  localparam int MUL_OUT_W  = 31;
  localparam int MUL_STAGES = 3;
  localparam int ID_MAX_W   = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mul_share_arbiter_mul_pipe.sv
// mul_pipe_16x16: 3-stage signed 16x16 multiplier, product truncated to 31 bits.
// Ports: clk, ce (stage enable), a/b operands, p registered product.
module mul_pipe_16x16
  import mul_share_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 ce,
  input  logic [MUL_IN_W-1:0]  a,
  input  logic [MUL_IN_W-1:0]  b,
  output logic [MUL_OUT_W-1:0] p
);

  localparam int EXT_W = MUL_OUT_W - MUL_IN_W;

  logic [MUL_IN_W-1:0]  a_q;
  logic [MUL_IN_W-1:0]  b_q;
  logic [MUL_OUT_W-1:0] a_x;
  logic [MUL_OUT_W-1:0] b_x;
  logic [MUL_OUT_W-1:0] prod_q;

  // Sign-extend to the product width; the low 31 bits of the
  // product are the truncated signed result.
  assign a_x = {{EXT_W{a_q[MUL_IN_W-1]}}, a_q};
  assign b_x = {{EXT_W{b_q[MUL_IN_W-1]}}, b_q};

  always_ff @(posedge clk) begin
    if (ce) begin
      a_q    <= a;
      b_q    <= b;
      prod_q <= a_x * b_x;
      p      <= prod_q;
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one pipelined 16x16 multiplier among requesters.
// Ports: req_valid/ready/a/b per requester, res_valid/ready/id/data, busy.
module mul_share_arbiter
  import mul_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*MUL_IN_W-1:0]   req_a,
  input  logic [NUM_REQ*MUL_IN_W-1:0]   req_b,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [ID_W-1:0]               res_id,
  output logic [MUL_OUT_W-1:0]          res_data,
  output logic                          busy
);

  localparam int LAST = MUL_STAGES - 1;

  tag_t                 tag_q [MUL_STAGES];
  logic                 ce;
  logic                 xfer;
  logic                 found;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      gnt_id;
  logic [ID_W:0]        idx;
  logic [NUM_REQ-1:0]   gnt;
  logic [MUL_IN_W-1:0]  a_sel;
  logic [MUL_IN_W-1:0]  b_sel;
  logic [MUL_OUT_W-1:0] p;
  logic                 unused_id_hi;

  assign ce = ~(tag_q[LAST].valid & ~res_ready);

  // Scan from rr_ptr with wraparound; first valid requester wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ))
        idx = idx - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        gnt_id = idx[ID_W-1:0];
      end
    end
    if (found)
      gnt[gnt_id] = 1'b1;
  end

  assign req_ready = (ce && !reset) ? gnt : '0;
  assign xfer      = |req_ready;

  assign a_sel = req_a[gnt_id*MUL_IN_W +: MUL_IN_W];
  assign b_sel = req_b[gnt_id*MUL_IN_W +: MUL_IN_W];

  mul_pipe_16x16 u_mul (
    .clk (clk),
    .ce  (ce),
    .a   (a_sel),
    .b   (b_sel),
    .p   (p)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      for (int i = 0; i < MUL_STAGES; i++)
        tag_q[i] <= '0;
    end else if (ce) begin
      tag_q[0].valid <= xfer;
      tag_q[0].id    <= ID_MAX_W'(gnt_id);
      for (int i = 1; i < MUL_STAGES; i++)
        tag_q[i] <= tag_q[i-1];
      if (xfer)
        rr_ptr <= (gnt_id == ID_W'(NUM_REQ-1))
                  ? '0 : gnt_id + 1'b1;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < MUL_STAGES; i++)
      busy = busy | tag_q[i].valid;
  end

  // Data registers are not reset; mask them whenever the tag is empty.
  assign res_valid = tag_q[LAST].valid;
  assign res_id    = res_valid ? tag_q[LAST].id[ID_W-1:0] : '0;
  assign res_data  = res_valid ? p : '0;

  assign unused_id_hi = ^tag_q[LAST].id;

endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing one multiplier (2..8).
REQ-002 Parameter ID_W, default 1, width of requester index, equal to max(1, clog2(NUM_REQ)).
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port req_valid  input  NUM_REQ  per-requester operand-pair valid.
REQ-006 Port req_ready  output  NUM_REQ  per-requester grant; at most one bit high per cycle.
REQ-007 Port req_a  input  NUM_REQ*16  packed signed operand A; requester i in bits [16i+15:16i].
REQ-008 Port req_b  input  NUM_REQ*16  packed signed operand B, same packing.
REQ-009 Port res_valid  output  1  product available.
REQ-010 Port res_ready  input  1  downstream accepts product.
REQ-011 Port res_id  output  ID_W  index of requester owning the product.
REQ-012 Port res_data  output  31  signed product a*b.
REQ-013 Port busy  output  1  high while any pipeline stage holds a valid entry.

Function
REQ-014 The block SHALL share one 3-register-stage signed 16x16->31 multiplier (input reg, product reg, output reg; common ce).
REQ-015 A transfer on requester i SHALL occur on a rising edge where req_valid[i] and req_ready[i] are both high.
REQ-016 Arbitration SHALL be round-robin: search starts at rr_ptr, and the first requester with req_valid high is granted.
REQ-017 req_ready SHALL be combinational from req_valid, rr_ptr and ce, and SHALL NOT depend on req_ready of other requesters.
REQ-018 After a transfer by requester i, rr_ptr SHALL become (i+1) mod NUM_REQ; rr_ptr SHALL hold when no transfer occurs.
REQ-019 ce SHALL equal NOT(res_valid AND NOT res_ready); when ce is low, req_ready SHALL be all zero and every stage SHALL hold.
REQ-020 A 3-deep tag pipeline {valid, id} SHALL advance with ce in lockstep with the multiplier stages.
REQ-021 With ce continuously high, an operand pair transferred at edge k SHALL appear on res_valid/res_id/res_data in the cycle after edge k+2, giving one issue per cycle and full throughput.
REQ-022 res_data SHALL equal the full-precision signed product truncated to 31 bits; (-32768)*(-32768) yields 31'h40000000 wrapped, i.e. bit 30 set.
REQ-023 res_data and res_id SHALL be driven to 0 whenever res_valid is low.
REQ-024 A pipeline bubble (no transfer on a ce-high edge) SHALL propagate as a valid=0 tag; bubbles SHALL NOT be compressed while ce is high.
REQ-025 Products SHALL be delivered in transfer order, with no loss or duplication across any res_ready stall pattern.
REQ-026 busy SHALL be the OR of all tag valid bits.

Reset
REQ-027 While reset is high: tag valid bits = 0, rr_ptr = 0, res_valid = 0, res_id = 0, res_data = 0, busy = 0, req_ready = 0.
REQ-028 Multiplier data registers need not be reset; REQ-023 masking SHALL hide their contents.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight products; the first edge after deassertion SHALL behave as after power-up.

Structure
REQ-030 Shared package SHALL hold MUL_IN_W=16, MUL_OUT_W=31, MUL_STAGES=3 and the tag record type {valid, id}.
REQ-031 The multiplier SHALL be the single sub-module mul_pipe_16x16 (ports clk, ce, a, b, p); arbiter, rr pointer, tag pipe and output masking SHALL stay in the top level.

Verification
REQ-032 Single request: req0 a=3, b=-5 at edge 0 -> res_valid in the cycle after edge 2, res_id=0, res_data=-15.
REQ-033 Both requesters valid every cycle, res_ready=1 -> grants alternate 0,1,0,1 and one result per cycle after the 3-cycle fill.
REQ-034 res_ready held low 4 cycles with 3 products in flight -> req_ready all 0 and outputs stable, then 3 products delivered in order, none lost.
REQ-035 Corner operands: a=b=-32768 -> res_data=31'h40000000; a=32767, b=-32768 -> -1073709056.
REQ-036 Reset asserted with 2 products in flight -> res_valid=0 and busy=0 immediately; after release, the first grant goes to requester 0.
